sar_compare_search: RTL

- Initiator side of the magnitude-compare interface.
- Drives a probe value to an external N-bit magnitude comparator, whose other operand is an unknown target.
- Reads back the greater/equal/less flags and resolves the target by successive approximation, MSB first, in at most N probe cycles.
- Used wherever a value is observable only through a compare result, for example threshold search or SAR-style conversion.

---
 rtl/sar_compare_search.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sar_compare_search.sv
// Successive-approximation search that resolves an unknown target through an external magnitude comparator.
// Optional SAR_COMPARE_SEARCH_VERIFY_EN adds a confirming VERIFY probe when the search ends without an eq hit.
module sar_compare_search #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  output logic [N-1:0] probe,
  output logic         probe_valid,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PTR_MSB = PW'(N - 1);
  localparam logic [N-1:0]  PROBE_MSB = N'(1) << (N - 1);

`ifdef SAR_COMPARE_SEARCH_VERIFY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [N-1:0]    probe_nxt, result_nxt, cand;
  logic            err_nxt;
  logic            flags_onehot;

  assign flags_onehot = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                        ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                        ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      probe  <= '0;
      result <= '0;
      ptr    <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      probe  <= probe_nxt;
      result <= result_nxt;
      ptr    <= ptr_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    probe_nxt  = probe;
    result_nxt = result;
    ptr_nxt    = ptr;
    err_nxt    = err;
    cand       = probe;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SEARCH;
          probe_nxt  = PROBE_MSB;
          ptr_nxt    = PTR_MSB;
          result_nxt = '0;
          err_nxt    = 1'b0;
        end
      end
      SEARCH: begin
        if (!flags_onehot) begin
          err_nxt    = 1'b1;
          result_nxt = probe;
          state_nxt  = DONE;
        end else if (cmp_eq) begin
          err_nxt    = 1'b0;
          result_nxt = probe;
          state_nxt  = DONE;
        end else begin
          if (cmp_lt) cand[ptr] = 1'b0;
          if (ptr != '0) begin
            cand[ptr - 1'b1] = 1'b1;
            probe_nxt        = cand;
            ptr_nxt          = ptr - 1'b1;
          end else if (cmp_lt) begin
`ifdef SAR_COMPARE_SEARCH_VERIFY_EN
            probe_nxt  = cand;
            state_nxt  = VERIFY;
`else
            result_nxt = cand;
            err_nxt    = 1'b0;
            state_nxt  = DONE;
`endif
          end else begin
            // gt on the last bit: target lies above every remaining candidate
            err_nxt    = 1'b1;
            result_nxt = probe;
            state_nxt  = DONE;
          end
        end
      end
`ifdef SAR_COMPARE_SEARCH_VERIFY_EN
      VERIFY: begin
        result_nxt = probe;
        err_nxt    = !(flags_onehot && cmp_eq);
        state_nxt  = DONE;
      end
`endif
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    probe_valid = 1'b0;
    done        = 1'b0;
    case (state)
      SEARCH: begin
        busy        = 1'b1;
        probe_valid = 1'b1;
      end
`ifdef SAR_COMPARE_SEARCH_VERIFY_EN
      VERIFY: begin
        busy        = 1'b1;
        probe_valid = 1'b1;
      end
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
